// File: rtl/exc_ctrl_if.sv
// Pipeline-side signal bundle for the exception controller: M/W-stage event inputs
// and the redirect/CP0 control outputs.
interface exc_ctrl_if;
    logic        i_int_req;
    logic        i_exc_req;
    logic [4:0]  i_exc_code_in;
    logic        i_eret_m;
    logic [31:0] i_pc4_m;
    logic        i_delay_w;

    logic        o_flush;
    logic [1:0]  o_pc_sel;
    logic        o_epc_we;
    logic [31:0] o_epc_val;
    logic [4:0]  o_exc_code;
    logic        o_exl_set;
    logic        o_exl_clr;
    logic        o_busy;

    modport slave (
        input  i_int_req, i_exc_req, i_exc_code_in, i_eret_m, i_pc4_m, i_delay_w,
        output o_flush, o_pc_sel, o_epc_we, o_epc_val, o_exc_code,
        o_exl_set, o_exl_clr, o_busy
    );

    modport master (
        output i_int_req, i_exc_req, i_exc_code_in, i_eret_m, i_pc4_m, i_delay_w,
        input  o_flush, o_pc_sel, o_epc_we, o_epc_val, o_exc_code,
        o_exl_set, o_exl_clr, o_busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt entry and eret return sequencer for a 5-stage MIPS-style pipeline.
// Every output is a flop loaded from the next-state decode, so nothing combinational leaves the block.
module exc_ctrl #(
    parameter logic [31:0] HANDLER  = 32'h0000_4180,
    parameter int unsigned ERET_LAT = 4
) (
    input  logic      clk,
    input  logic      reset,
    exc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        DRAIN,
        ERET_WAIT
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ERET_LAT);

    if (ERET_LAT < 1 || ERET_LAT > 15) begin : g_bad_lat
        $error("exc_ctrl: ERET_LAT must lie in 1..15");
    end
    if (HANDLER[1:0] != 2'b00) begin : g_bad_handler
        $error("exc_ctrl: HANDLER must be word aligned");
    end

    state_t      r_state,    w_state_nxt;
    logic [3:0]  r_cnt,      w_cnt_nxt;
    logic [31:0] r_epc_val,  w_epc_val_nxt;
    logic [4:0]  r_exc_code, w_exc_code_nxt;
    logic        r_flush,    w_flush_nxt;
    logic [1:0]  r_pc_sel,   w_pc_sel_nxt;
    logic        r_epc_we,   w_epc_we_nxt;
    logic        r_exl_set,  w_exl_set_nxt;
    logic        r_exl_clr,  w_exl_clr_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        w_take;

    // Event arbitration: in IDLE exc > int > eret; in ERET_WAIT only exc can interrupt the countdown.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_epc_val_nxt  = r_epc_val;
        w_exc_code_nxt = r_exc_code;
        w_take         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_exc_req || bus.i_int_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ENTER;
                end else if (bus.i_eret_m) begin
                    w_state_nxt = ERET_WAIT;
                    w_cnt_nxt   = LAT_INIT;
                end
            end
            ENTER:   w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            ERET_WAIT: begin
                if (bus.i_exc_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ENTER;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_take) begin
            w_epc_val_nxt  = bus.i_pc4_m - (bus.i_delay_w ? 32'd8 : 32'd4);
            w_exc_code_nxt = bus.i_exc_req ? bus.i_exc_code_in : 5'd0;
        end
    end

    // Output decode for the cycle that follows this edge; exl_clr marks the final countdown cycle.
    always_comb begin
        w_flush_nxt   = 1'b0;
        w_pc_sel_nxt  = 2'b00;
        w_epc_we_nxt  = 1'b0;
        w_exl_set_nxt = 1'b0;
        w_exl_clr_nxt = 1'b0;
        w_busy_nxt    = (w_state_nxt != IDLE);
        case (w_state_nxt)
            ENTER: begin
                w_flush_nxt   = 1'b1;
                w_pc_sel_nxt  = 2'b01;
                w_epc_we_nxt  = 1'b1;
                w_exl_set_nxt = 1'b1;
            end
            DRAIN: w_flush_nxt = 1'b1;
            ERET_WAIT: begin
                if (r_state == IDLE) begin
                    w_flush_nxt  = 1'b1;
                    w_pc_sel_nxt = 2'b10;
                end
                w_exl_clr_nxt = (w_cnt_nxt == 4'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_epc_val  <= 32'd0;
            r_exc_code <= 5'd0;
            r_flush    <= 1'b0;
            r_pc_sel   <= 2'b00;
            r_epc_we   <= 1'b0;
            r_exl_set  <= 1'b0;
            r_exl_clr  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_epc_val  <= w_epc_val_nxt;
            r_exc_code <= w_exc_code_nxt;
            r_flush    <= w_flush_nxt;
            r_pc_sel   <= w_pc_sel_nxt;
            r_epc_we   <= w_epc_we_nxt;
            r_exl_set  <= w_exl_set_nxt;
            r_exl_clr  <= w_exl_clr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.o_flush    = r_flush;
    assign bus.o_pc_sel   = r_pc_sel;
    assign bus.o_epc_we   = r_epc_we;
    assign bus.o_epc_val  = r_epc_val;
    assign bus.o_exc_code = r_exc_code;
    assign bus.o_exl_set  = r_exl_set;
    assign bus.o_exl_clr  = r_exl_clr;
    assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: interrupt/exception entry, delay-slot EPC, eret countdown,
// eret abort, EPC wraparound and synchronous reset mid-sequence.
module tb_exc_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   nCompared   = 0;
    int   nMismatched = 0;

    exc_ctrl_if bus ();

    exc_ctrl #(.HANDLER(32'h0000_4180), .ERET_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic intReq, input logic excReq, input logic [4:0] code,
                                 input logic eret, input logic [31:0] pc4, input logic delay);
        bus.i_int_req     = intReq;
        bus.i_exc_req     = excReq;
        bus.i_exc_code_in = code;
        bus.i_eret_m      = eret;
        bus.i_pc4_m       = pc4;
        bus.i_delay_w     = delay;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic flush, input logic [1:0] pcSel,
                            input logic epcWe, input logic exlSet, input logic exlClr, input logic busy);
        checkOutput({tag, ".flush"},  32'(bus.o_flush),   32'(flush));
        checkOutput({tag, ".pc_sel"}, 32'(bus.o_pc_sel),  32'(pcSel));
        checkOutput({tag, ".epc_we"}, 32'(bus.o_epc_we),  32'(epcWe));
        checkOutput({tag, ".exl_set"}, 32'(bus.o_exl_set), 32'(exlSet));
        checkOutput({tag, ".exl_clr"}, 32'(bus.o_exl_clr), 32'(exlClr));
        checkOutput({tag, ".busy"},   32'(bus.o_busy),    32'(busy));
    endtask

    task automatic checkLatched(input string tag, input logic [31:0] epc, input logic [4:0] code);
        checkOutput({tag, ".epc_val"},  bus.o_epc_val,        epc);
        checkOutput({tag, ".exc_code"}, 32'(bus.o_exc_code),  32'(code));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        repeat (2) nextCycle();
        checkCtl("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkLatched("reset", 32'h0, 5'd0);
        reset = 1'b0;
        nextCycle();
        checkCtl("idle0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Interrupt entry; a second request held through ENTER/DRAIN must be ignored.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 32'h0000_3010, 1'b0);
        nextCycle();
        checkCtl("int.enter", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        checkLatched("int.enter", 32'h0000_300C, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd10, 1'b1, 32'h0000_5000, 1'b0);
        nextCycle();
        checkCtl("int.drain", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("int.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkLatched("int.hold", 32'h0000_300C, 5'd0);

        // Exception beats a simultaneous interrupt; delay slot rewinds EPC by 8.
        applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 32'h0000_3020, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("exc.enter", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        checkLatched("exc.enter", 32'h0000_3018, 5'd12);
        nextCycle();
        checkCtl("exc.drain", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkCtl("exc.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Eret: redirect on cycle 1, exl_clr on cycle 4; interrupts held meanwhile are ignored.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_7000, 1'b0);
        checkCtl("eret.c1", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkCtl("eret.c2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkCtl("eret.c3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("eret.c4", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkCtl("eret.done", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkLatched("eret.hold", 32'h0000_3018, 5'd12);

        // Eret aborted by an exception in its second cycle.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("abort.c1", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 32'h0000_4000, 1'b0);
        checkCtl("abort.c2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("abort.enter", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        checkLatched("abort.enter", 32'h0000_3FFC, 5'd10);
        nextCycle();
        checkCtl("abort.drain", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkCtl("abort.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // EPC computation wraps modulo 2^32.
        applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 32'h0000_0004, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkLatched("wrap", 32'hFFFF_FFFC, 5'd10);
        repeat (2) nextCycle();
        checkCtl("wrap.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during ENTER wipes outputs; interrupt held during the reset edge is discarded.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 32'h0000_0100, 1'b0);
        nextCycle();
        checkCtl("rst.enter", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        checkLatched("rst.enter", 32'h0000_00FC, 5'd0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("rst.enter.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkLatched("rst.enter.after", 32'h0, 5'd0);
        nextCycle();
        checkCtl("rst.int.dropped", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-countdown: exl_clr must never appear for the killed eret.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkCtl("rst.eret.c1", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkCtl("rst.eret.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter HANDLER, default 32'h0000_4180, exception handler entry address.
REQ-002 Parameter ERET_LAT, default 4, cycles from eret acceptance to EXL clear (range 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-005 int_req  input  1  masked interrupt request from CP0 (IM, IE and ~EXL already applied).
REQ-006 exc_req  input  1  synchronous exception flagged by the M stage.
REQ-007 exc_code_in  input  5  ExcCode[6:2] accompanying exc_req (10 illegal instruction, 12 overflow).
REQ-008 eret_m  input  1  eret instruction present in the M stage.
REQ-009 pc4_m  input  32  PC+4 of the M-stage instruction.
REQ-010 delay_w  input  1  W-stage instruction is a branch or jump, so the M-stage instruction is in a delay slot.
REQ-011 flush  output  1  kill F/D/E/M pipeline registers.
REQ-012 pc_sel  output  2  00 sequential, 01 HANDLER, 10 EPC.
REQ-013 epc_we  output  1  write epc_val into CP0 EPC.
REQ-014 epc_val  output  32  EPC value to write.
REQ-015 exc_code  output  5  ExcCode written to CP0 Cause[6:2] when epc_we is high.
REQ-016 exl_set  output  1  set SR.EXL.
REQ-017 exl_clr  output  1  clear SR.EXL.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, ENTER, DRAIN, ERET_WAIT; all outputs are registered Moore outputs decoded from state and holding registers.
REQ-020 In IDLE, priority on each edge is exc_req > int_req > eret_m; the winning event is accepted on that edge and lower-priority events are dropped, not queued.
REQ-021 Acceptance of exc_req or int_req moves IDLE->ENTER and latches epc_val = delay_w ? pc4_m-8 : pc4_m-4, computed modulo 2^32.
REQ-022 On the same edge, exc_code latches exc_code_in for exc_req and 5'd0 for int_req.
REQ-023 ENTER lasts exactly 1 cycle and drives flush=1, pc_sel=01, epc_we=1, exl_set=1; next state is DRAIN.
REQ-024 DRAIN lasts exactly 1 cycle and drives flush=1, pc_sel=00, epc_we=0, exl_set=0; next state is IDLE.
REQ-025 Acceptance of eret_m moves IDLE->ERET_WAIT, drives flush=1 and pc_sel=10 for the first ERET_WAIT cycle only, and loads a 4-bit down-counter with ERET_LAT.
REQ-026 In ERET_WAIT the counter decrements by 1 per cycle.
REQ-027 When the counter reaches 1, exl_clr=1 for exactly that cycle, and the next state is IDLE.
REQ-028 An exc_req arriving in ERET_WAIT aborts the countdown: the exception is accepted per REQ-021/022, the next state is ENTER, and exl_clr is never asserted for that eret.
REQ-029 int_req and eret_m arriving in ERET_WAIT are ignored.
REQ-030 All of exc_req, int_req and eret_m arriving in ENTER or DRAIN are ignored.
REQ-031 Outside the cases above: flush=0, pc_sel=00, epc_we=0, exl_set=0, exl_clr=0.
REQ-032 epc_val and exc_code hold their last latched value until the next accepted exception or interrupt.
REQ-033 exl_set and exl_clr are never high in the same cycle.
REQ-034 Entry latency: an event accepted on edge N produces its outputs in the cycle following edge N.

Reset
REQ-035 While reset is high on a rising edge, the next state is IDLE.
REQ-036 Reset applies from any state, including mid-ENTER, mid-DRAIN and mid-countdown.
REQ-037 Reset values: flush=0, pc_sel=00, epc_we=0, exl_set=0, exl_clr=0, busy=0, epc_val=0, exc_code=0, counter=0.
REQ-038 Inputs sampled on the edge where reset is high are discarded.

Verification
REQ-039 Interrupt entry: int_req=1, pc4_m=32'h0000_3010, delay_w=0 -> next cycle flush=1, pc_sel=01, epc_we=1, epc_val=32'h0000_300C, exc_code=0, exl_set=1; then one DRAIN cycle; then IDLE.
REQ-040 Delay slot with priority: exc_req=1, exc_code_in=12, int_req=1, delay_w=1, pc4_m=32'h0000_3020 -> epc_val=32'h0000_3018, exc_code=12.
REQ-041 Eret: eret_m=1 with ERET_LAT=4 -> pc_sel=10 and flush=1 for 1 cycle; exl_clr=1 exactly 4 cycles after acceptance; busy=0 afterwards.
REQ-042 Abort: exc_req=1 in the 2nd ERET_WAIT cycle -> ENTER next cycle and exl_clr never asserted.
REQ-043 Wrap: pc4_m=32'h0000_0004, delay_w=1 -> epc_val=32'hFFFF_FFFC.
REQ-044 Reset: reset=1 during ENTER -> next cycle all outputs at REQ-037 values; int_req held high in that cycle is not accepted.
